// File: rtl/ball_speed_ctrl_pkg.sv
// Shared game constants: rally FSM encoding, default speed-divider values
// and the clamped speed-step helper used by the ball speed controller.
package ball_speed_ctrl_pkg;

  localparam int SPEED_W = 26;
  localparam int HOLD_W  = 16;
  localparam int HITS_W  = 8;

  localparam logic [SPEED_W-1:0] GAME_BASE_SPEED = 26'd12_500_000;
  localparam logic [SPEED_W-1:0] GAME_STEP       = 26'd213_568;
  localparam logic [SPEED_W-1:0] GAME_MIN_SPEED  = 26'd2_000_000;
  localparam logic [HOLD_W-1:0]  GAME_HOLDOFF    = 16'd50_000;

  localparam logic [HITS_W-1:0]  HITS_MAX        = 8'd255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RALLY   = 2'd1,
    LOCKOUT = 2'd2
  } rally_state_t;

  // One step faster: a smaller compare value means a faster ball. The
  // subtraction carries one extra bit so a borrow is seen instead of a wrap,
  // and the result never drops below the floor.
  function automatic logic [SPEED_W-1:0] speed_after_hit(
    input logic [SPEED_W-1:0] speed,
    input logic [SPEED_W-1:0] step,
    input logic [SPEED_W-1:0] floor
  );
    logic [SPEED_W:0] diff;
    diff = {1'b0, speed} - {1'b0, step};
    if (diff[SPEED_W] || (diff[SPEED_W-1:0] < floor)) begin
      return floor;
    end else begin
      return diff[SPEED_W-1:0];
    end
  endfunction

endpackage

// File: rtl/ball_speed_ctrl_rise_detect.sv
// Rising-edge detector: the level is registered once, then compared with
// its own previous sample, so a level already high when reset releases
// cannot flag an edge in the first cycle.
module rise_detect (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_cur;
  logic r_prev;

  // Two-deep sample history of the incoming level.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_level;
      r_prev <= r_cur;
    end
  end

  assign o_rise = r_cur & ~r_prev;

endmodule

// File: rtl/ball_speed_ctrl.sv
// Ball speed controller: starts at BASE_SPEED on serve, speeds the ball up
// by STEP on every accepted paddle hit (clamped at MIN_SPEED), locks out
// further hits for HOLDOFF cycles, and restores BASE_SPEED when a point ends
// the rally. HOLDOFF is expected to be at least 1.
module ball_speed_ctrl
  import ball_speed_ctrl_pkg::*;
#(
  parameter logic [SPEED_W-1:0] BASE_SPEED = GAME_BASE_SPEED,
  parameter logic [SPEED_W-1:0] STEP       = GAME_STEP,
  parameter logic [SPEED_W-1:0] MIN_SPEED  = GAME_MIN_SPEED,
  parameter logic [HOLD_W-1:0]  HOLDOFF    = GAME_HOLDOFF
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               serve,
  input  logic               hit,
  input  logic               point_scored,
  output logic [SPEED_W-1:0] ball_speed,
  output logic               speed_changed,
  output logic [HITS_W-1:0]  rally_hits,
  output logic               at_max_speed
);

  rally_state_t       r_state;
  logic [SPEED_W-1:0] r_ball_speed;
  logic               r_speed_changed;
  logic [HITS_W-1:0]  r_rally_hits;
  logic [HOLD_W-1:0]  r_lock_cnt;

  rally_state_t       w_state_nxt;
  logic [SPEED_W-1:0] w_speed_nxt;
  logic [HITS_W-1:0]  w_hits_nxt;
  logic [HOLD_W-1:0]  w_cnt_nxt;
  logic               w_changed_nxt;

  logic               w_serve_rise;
  logic               w_hit_rise;

  rise_detect u_serve_rise (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_level (serve),
    .o_rise  (w_serve_rise)
  );

  rise_detect u_hit_rise (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_level (hit),
    .o_rise  (w_hit_rise)
  );

  // State, speed, hit count, lockout counter and change pulse registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_ball_speed    <= BASE_SPEED;
      r_speed_changed <= 1'b0;
      r_rally_hits    <= '0;
      r_lock_cnt      <= '0;
    end else begin
      r_state         <= w_state_nxt;
      r_ball_speed    <= w_speed_nxt;
      r_speed_changed <= w_changed_nxt;
      r_rally_hits    <= w_hits_nxt;
      r_lock_cnt      <= w_cnt_nxt;
    end
  end

  // Rally sequencing; a point always wins over a same-cycle hit.
  always_comb begin
    w_state_nxt = r_state;
    w_speed_nxt = r_ball_speed;
    w_hits_nxt  = r_rally_hits;
    w_cnt_nxt   = r_lock_cnt;

    case (r_state)
      IDLE: begin
        w_speed_nxt = BASE_SPEED;
        if (w_serve_rise) begin
          w_state_nxt = RALLY;
          w_hits_nxt  = '0;
        end
      end

      RALLY: begin
        if (point_scored) begin
          w_state_nxt = IDLE;
          w_speed_nxt = BASE_SPEED;
          w_cnt_nxt   = '0;
        end else if (w_hit_rise) begin
          w_state_nxt = LOCKOUT;
          w_speed_nxt = speed_after_hit(r_ball_speed, STEP, MIN_SPEED);
          w_hits_nxt  = (r_rally_hits == HITS_MAX) ? HITS_MAX
                                                   : r_rally_hits + 8'd1;
          w_cnt_nxt   = HOLDOFF - 16'd1;
        end
      end

      LOCKOUT: begin
        if (point_scored) begin
          w_state_nxt = IDLE;
          w_speed_nxt = BASE_SPEED;
          w_cnt_nxt   = '0;
        end else if (r_lock_cnt == '0) begin
          w_state_nxt = RALLY;
        end else begin
          w_cnt_nxt = r_lock_cnt - 16'd1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_speed_nxt = BASE_SPEED;
        w_cnt_nxt   = '0;
      end
    endcase

    w_changed_nxt = (w_speed_nxt != r_ball_speed);
  end

  assign ball_speed    = r_ball_speed;
  assign speed_changed = r_speed_changed;
  assign rally_hits    = r_rally_hits;
  assign at_max_speed  = (r_ball_speed == MIN_SPEED);

endmodule

// File: tb/tb_ball_speed_ctrl.sv
// Self-checking bench for ball_speed_ctrl: directed rally scenarios with a
// queue of expected results per accepted hit or point.
module tb_ball_speed_ctrl;
  import ball_speed_ctrl_pkg::*;

  localparam logic [25:0] T_BASE = 26'd100;
  localparam logic [25:0] T_STEP = 26'd30;
  localparam logic [25:0] T_MIN  = 26'd20;
  localparam logic [15:0] T_HOLD = 16'd4;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b0;
  logic        serve = 1'b0, hit = 1'b0, point_scored = 1'b0;
  logic [25:0] ball_speed;
  logic        speed_changed;
  logic [7:0]  rally_hits;
  logic        at_max_speed;

  logic        serve2 = 1'b0, hit2 = 1'b0, point2 = 1'b0;
  logic [25:0] ball_speed2;
  logic        speed_changed2;
  logic [7:0]  rally_hits2;
  logic        at_max_speed2;

  ball_speed_ctrl #(.BASE_SPEED(T_BASE), .STEP(T_STEP), .MIN_SPEED(T_MIN), .HOLDOFF(T_HOLD)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .serve(serve), .hit(hit), .point_scored(point_scored),
    .ball_speed(ball_speed), .speed_changed(speed_changed), .rally_hits(rally_hits),
    .at_max_speed(at_max_speed)
  );

  ball_speed_ctrl #(.BASE_SPEED(T_BASE), .STEP(T_STEP), .MIN_SPEED(T_BASE), .HOLDOFF(T_HOLD)) dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .serve(serve2), .hit(hit2), .point_scored(point2),
    .ball_speed(ball_speed2), .speed_changed(speed_changed2), .rally_hits(rally_hits2),
    .at_max_speed(at_max_speed2)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [25:0] speed;
    logic [7:0]  hits;
    logic        changed;
  } exp_t;

  exp_t sbq[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   pulseCount  = 0;
  int   pulseCount2 = 0;
  int   expSpeed;
  int   expHits;

  // Count speed_changed pulses mid-cycle, away from the updating edge.
  always @(negedge clk_in) begin
    if (speed_changed)  pulseCount++;
    if (speed_changed2) pulseCount2++;
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic h, input logic p);
    serve        = s;
    hit          = h;
    point_scored = p;
  endtask

  task automatic applyReset();
    applyStimulus(1'b0, 1'b0, 1'b0);
    serve2 = 1'b0; hit2 = 1'b0; point2 = 1'b0;
    rst_n  = 1'b0;
    repeat (2) tick();
    @(negedge clk_in);
    rst_n = 1'b1;
    tick();
    expSpeed = 100;
    expHits  = 0;
    sbq.delete();
  endtask

  task automatic startRally();
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Independent speed/hit model: push what one accepted hit should produce.
  task automatic pushHit(input int minSpeed);
    exp_t e;
    int   nxt;
    nxt = expSpeed - 30;
    if (nxt < minSpeed) nxt = minSpeed;
    expHits   = (expHits >= 255) ? 255 : expHits + 1;
    e.speed   = 26'(nxt);
    e.hits    = 8'(expHits);
    e.changed = (nxt != expSpeed);
    expSpeed  = nxt;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    applyStimulus(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    assertCount++;
    if ({ball_speed, speed_changed, rally_hits, at_max_speed} !== {26'd100, 1'b0, 8'd0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL reset_outputs: speed=%0d chg=%0b hits=%0d max=%0b, required 100 0 0 0",
               ball_speed, speed_changed, rally_hits, at_max_speed);
    end
    assertCount++;
    if (dut.r_state !== IDLE) begin
      failCount++;
      $display("[TB] FAIL reset_state: got %0d, required %0d", dut.r_state, IDLE);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    tick();
    assertCount++;
    if (dut.r_state !== IDLE) begin
      failCount++;
      $display("[TB] FAIL reset_release_no_edge: state %0d, required %0d", dut.r_state, IDLE);
    end
    e.speed = 26'd100; e.hits = 8'd0; e.changed = 1'b0;
    assertCount++;
    if ({ball_speed, rally_hits, speed_changed} !== {e.speed, e.hits, e.changed}) begin
      failCount++;
      $display("[TB] FAIL reset_release_outputs: speed=%0d hits=%0d chg=%0b, required 100 0 0",
               ball_speed, rally_hits, speed_changed);
    end
  endtask

  task automatic test_serve();
    int p0;
    applyReset();
    p0 = pulseCount;
    startRally();
    assertCount++;
    if (dut.r_state !== RALLY) begin
      failCount++;
      $display("[TB] FAIL serve_state: got %0d, required %0d", dut.r_state, RALLY);
    end
    assertCount++;
    if ({ball_speed, rally_hits, speed_changed} !== {26'd100, 8'd0, 1'b0} || pulseCount != p0) begin
      failCount++;
      $display("[TB] FAIL serve_outputs: speed=%0d hits=%0d chg=%0b pulses=%0d, required 100 0 0 0",
               ball_speed, rally_hits, speed_changed, pulseCount - p0);
    end
  endtask

  task automatic test_hit_sequence();
    exp_t e;
    int   p0;
    applyReset();
    startRally();
    p0 = pulseCount;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      pushHit(20);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      e = sbq.pop_front();
      assertCount++;
      if ({ball_speed, rally_hits, speed_changed} !== {e.speed, e.hits, e.changed}) begin
        failCount++;
        $display("[TB] FAIL hit_%0d: speed=%0d hits=%0d chg=%0b, required %0d %0d %0b",
                 i, ball_speed, rally_hits, speed_changed, e.speed, e.hits, e.changed);
      end
      assertCount++;
      if (at_max_speed !== (e.speed == 26'd20)) begin
        failCount++;
        $display("[TB] FAIL at_max_%0d: got %0b, required %0b", i, at_max_speed, e.speed == 26'd20);
      end
      repeat (4) tick();
    end
    assertCount++;
    if (pulseCount - p0 != 3) begin
      failCount++;
      $display("[TB] FAIL hit_pulse_count: got %0d, required 3", pulseCount - p0);
    end
  endtask

  task automatic test_lockout();
    exp_t e;
    int   p0;
    applyReset();
    startRally();
    p0 = pulseCount;
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushHit(20);
    repeat (2) tick();
    e = sbq.pop_front();
    assertCount++;
    if ({ball_speed, rally_hits, speed_changed} !== {e.speed, e.hits, e.changed}) begin
      failCount++;
      $display("[TB] FAIL held_hit_accept: speed=%0d hits=%0d chg=%0b, required %0d %0d %0b",
               ball_speed, rally_hits, speed_changed, e.speed, e.hits, e.changed);
    end
    repeat (18) tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    assertCount++;
    if ({ball_speed, rally_hits} !== {26'd70, 8'd1} || pulseCount - p0 != 1) begin
      failCount++;
      $display("[TB] FAIL held_hit_once: speed=%0d hits=%0d pulses=%0d, required 70 1 1",
               ball_speed, rally_hits, pulseCount - p0);
    end

    applyReset();
    startRally();
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushHit(20);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    e = sbq.pop_front();
    assertCount++;
    if ({ball_speed, rally_hits, speed_changed} !== {e.speed, e.hits, e.changed}) begin
      failCount++;
      $display("[TB] FAIL bounce_first: speed=%0d hits=%0d chg=%0b, required %0d %0d %0b",
               ball_speed, rally_hits, speed_changed, e.speed, e.hits, e.changed);
    end
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (7) tick();
    assertCount++;
    if ({ball_speed, rally_hits} !== {26'd70, 8'd1} || dut.r_state !== RALLY) begin
      failCount++;
      $display("[TB] FAIL bounce_ignored: speed=%0d hits=%0d state=%0d, required 70 1 %0d",
               ball_speed, rally_hits, dut.r_state, RALLY);
    end
  endtask

  task automatic test_point_vs_hit();
    exp_t e;
    int   p0;
    applyReset();
    startRally();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      pushHit(20);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      e = sbq.pop_front();
      assertCount++;
      if ({ball_speed, rally_hits, speed_changed} !== {e.speed, e.hits, e.changed}) begin
        failCount++;
        $display("[TB] FAIL pvh_setup_%0d: speed=%0d hits=%0d chg=%0b, required %0d %0d %0b",
                 i, ball_speed, rally_hits, speed_changed, e.speed, e.hits, e.changed);
      end
      repeat (4) tick();
    end
    p0 = pulseCount;
    applyStimulus(1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    e.speed = 26'd100; e.hits = 8'(expHits); e.changed = 1'b1;
    sbq.push_back(e);
    expSpeed = 100;
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    e = sbq.pop_front();
    assertCount++;
    if ({ball_speed, rally_hits, speed_changed} !== {e.speed, e.hits, e.changed} || dut.r_state !== IDLE) begin
      failCount++;
      $display("[TB] FAIL point_wins: speed=%0d hits=%0d chg=%0b state=%0d, required %0d %0d %0b %0d",
               ball_speed, rally_hits, speed_changed, dut.r_state, e.speed, e.hits, e.changed, IDLE);
    end
    repeat (3) tick();
    applyStimulus(1'b0, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    assertCount++;
    if ({ball_speed, rally_hits} !== {26'd100, 8'd2} || pulseCount - p0 != 1 || dut.r_state !== IDLE) begin
      failCount++;
      $display("[TB] FAIL point_idle_hold: speed=%0d hits=%0d pulses=%0d state=%0d, required 100 2 1 %0d",
               ball_speed, rally_hits, pulseCount - p0, dut.r_state, IDLE);
    end
    startRally();
    assertCount++;
    if (rally_hits !== 8'd0 || dut.r_state !== RALLY) begin
      failCount++;
      $display("[TB] FAIL reserve_clear: hits=%0d state=%0d, required 0 %0d",
               rally_hits, dut.r_state, RALLY);
    end
  endtask

  task automatic test_reset_in_lockout();
    exp_t e;
    int   p0;
    applyReset();
    startRally();
    applyStimulus(1'b0, 1'b1, 1'b0);
    pushHit(20);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick();
    e = sbq.pop_front();
    assertCount++;
    if ({ball_speed, speed_changed} !== {e.speed, e.changed} || dut.r_state !== LOCKOUT) begin
      failCount++;
      $display("[TB] FAIL lockout_entry: speed=%0d chg=%0b state=%0d, required %0d %0b %0d",
               ball_speed, speed_changed, dut.r_state, e.speed, e.changed, LOCKOUT);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    #2;
    p0 = pulseCount;
    rst_n = 1'b0;
    #1;
    assertCount++;
    if ({ball_speed, speed_changed, rally_hits} !== {26'd100, 1'b0, 8'd0} || dut.r_state !== IDLE) begin
      failCount++;
      $display("[TB] FAIL async_reset: speed=%0d chg=%0b hits=%0d state=%0d, required 100 0 0 %0d",
               ball_speed, speed_changed, rally_hits, dut.r_state, IDLE);
    end
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (5) tick();
    assertCount++;
    if ({ball_speed, rally_hits} !== {26'd100, 8'd0} || pulseCount != p0 || dut.r_state !== IDLE) begin
      failCount++;
      $display("[TB] FAIL post_reset_hit: speed=%0d hits=%0d pulses=%0d state=%0d, required 100 0 0 %0d",
               ball_speed, rally_hits, pulseCount - p0, dut.r_state, IDLE);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    exp_t e;
    int   p0;
    int   bad;
    applyReset();
    serve2 = 1'b1;
    repeat (2) tick();
    serve2 = 1'b0;
    p0  = pulseCount2;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      hit2 = 1'b1;
      pushHit(100);
      tick();
      hit2 = 1'b0;
      tick();
      e = sbq.pop_front();
      assertCount++;
      if ({ball_speed2, rally_hits2, speed_changed2} !== {e.speed, e.hits, e.changed}) begin
        failCount++;
        if (bad < 5)
          $display("[TB] FAIL sat_hit_%0d: speed=%0d hits=%0d chg=%0b, required %0d %0d %0b",
                   i, ball_speed2, rally_hits2, speed_changed2, e.speed, e.hits, e.changed);
        bad++;
      end
      repeat (4) tick();
    end
    assertCount++;
    if (rally_hits2 !== 8'd255 || pulseCount2 != p0 || at_max_speed2 !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL saturate_final: hits=%0d pulses=%0d max=%0b, required 255 0 1",
               rally_hits2, pulseCount2 - p0, at_max_speed2);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_hit_sequence();
    test_lockout();
    test_point_vs_hit();
    test_reset_in_lockout();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #500000;
    failCount++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
